down_fifo_packet_reader: RTL and testbench

Drains the downstream (fiber-to-host) 32-bit FIFO and delimits its word stream into packets for the DMA engine. Each packet arrives as a header, a payload and an XOR checksum trailer. The block checks the header and the checksum, forwards only payload words over a valid/ready stream with an end-of-packet marker, and keeps saturating packet and error counters. Its FIFO-side signals (`fifo_dat_i`, `fifo_empty_i`, `fifo_rd_en_o`) are the same nets the downstream FIFO debug monitor taps.

---
 rtl/down_fifo_pkg.sv | 24 ++
 rtl/down_pkt_obuf.sv | 48 ++++
 rtl/down_fifo_packet_reader.sv | 131 +++++++++++++
 tb/tb_down_fifo_packet_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_fifo_pkg.sv
// Shared definitions for the downstream FIFO packet reader: parser states,
// header field layout, counter width and a saturating increment helper.
package down_fifo_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA5A5;

    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_MAGIC_LSB = 16;
    localparam int HDR_LEN_MSB   = 15;
    localparam int HDR_LEN_LSB   = 0;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/down_pkt_obuf.sv
// Two-entry valid/ready output buffer; occupancy feeds the upstream read-credit logic.
module down_pkt_obuf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    input  logic         rd_ready,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // Handshake: a word moves out on rd_valid && rd_ready; rd_data holds while stalled.
    assign rd_valid  = (count != 2'd0);
    assign rd_data   = mem[rd_ptr];
    assign occupancy = count;
    assign pop       = rd_valid && rd_ready;
    assign push      = wr_en && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/down_fifo_packet_reader.sv
// Drains the downstream FIFO, validates header/XOR trailer and forwards payload words
// with an end-of-packet marker; keeps saturating good-packet and error counters.
module down_fifo_packet_reader
    import down_fifo_pkg::*;
#(
    parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEFAULT,
    parameter int unsigned MAX_LEN   = 1024
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [31:0]      fifo_dat_i,
    input  logic             fifo_empty_i,
    input  logic             fifo_valid_i,
    output logic             fifo_rd_en_o,
    output logic [31:0]      out_data_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic             pkt_done_o,
    output logic             pkt_err_o,
    output logic             hdr_err_o,
    output logic [CNT_W-1:0] pkt_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output state_t           dbg_state_o
);

    state_t      state;
    state_t      state_next;
    logic        in_flight;
    logic [15:0] remain;
    logic [31:0] csum;
    logic [1:0]  occupancy;
    logic        word_ok;
    logic        hdr_ok;
    logic [15:0] hdr_len;
    logic        buf_wr;
    logic        buf_last;

    // Only data from a read issued since reset counts; a stale strobe is dropped.
    assign word_ok = fifo_valid_i && in_flight;
    assign hdr_len = fifo_dat_i[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_ok  = (fifo_dat_i[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == HDR_MAGIC)
                     && (hdr_len != 16'd0) && (32'(hdr_len) <= MAX_LEN);

    assign fifo_rd_en_o = reset_n_i && !fifo_empty_i
                          && (({1'b0, occupancy} + {2'b00, in_flight}) < 3'd2);
    assign dbg_state_o  = state;

    always_comb begin
        state_next = state;
        buf_wr     = 1'b0;
        buf_last   = 1'b0;
        if (word_ok) begin
            case (state)
                ST_HUNT: begin
                    if (hdr_ok) state_next = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    buf_wr   = 1'b1;
                    buf_last = (remain == 16'd1);
                    if (remain == 16'd1) state_next = ST_TRAILER;
                end
                ST_TRAILER: state_next = ST_HUNT;
                default:    state_next = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state       <= ST_HUNT;
            in_flight   <= 1'b0;
            remain      <= 16'd0;
            csum        <= 32'd0;
            pkt_done_o  <= 1'b0;
            pkt_err_o   <= 1'b0;
            hdr_err_o   <= 1'b0;
            pkt_count_o <= '0;
            err_count_o <= '0;
        end else begin
            state      <= state_next;
            pkt_done_o <= 1'b0;
            pkt_err_o  <= 1'b0;
            hdr_err_o  <= 1'b0;
            if (fifo_rd_en_o) begin
                in_flight <= 1'b1;
            end else if (fifo_valid_i) begin
                in_flight <= 1'b0;
            end
            if (word_ok) begin
                case (state)
                    ST_HUNT: begin
                        if (hdr_ok) begin
                            remain <= hdr_len;
                            csum   <= 32'd0;
                        end else begin
                            hdr_err_o   <= 1'b1;
                            err_count_o <= sat_inc(err_count_o);
                        end
                    end
                    ST_PAYLOAD: begin
                        remain <= remain - 16'd1;
                        csum   <= csum ^ fifo_dat_i;
                    end
                    ST_TRAILER: begin
                        pkt_done_o <= 1'b1;
                        pkt_err_o  <= (fifo_dat_i != csum);
                        if (fifo_dat_i != csum) begin
                            err_count_o <= sat_inc(err_count_o);
                        end else begin
                            pkt_count_o <= sat_inc(pkt_count_o);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    down_pkt_obuf #(.W(33)) u_obuf (
        .clk       (clk_i),
        .reset_n   (reset_n_i),
        .wr_en     (buf_wr),
        .wr_data   ({buf_last, fifo_dat_i}),
        .rd_valid  (out_valid_o),
        .rd_data   ({out_last_o, out_data_o}),
        .rd_ready  (out_ready_i),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_down_fifo_packet_reader.sv
// Bench for down_fifo_packet_reader: FIFO model, packet-level reference model,
// beat/event scoreboards and directed plus randomized packet streams.
module tb_down_fifo_packet_reader;
    import down_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] fifo_dat;
    logic        fifo_empty;
    logic        fifo_valid;
    logic        fifo_rd_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        pkt_done;
    logic        pkt_err;
    logic        hdr_err;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    logic [32:0] exp_q[$];
    logic [1:0]  ev_q[$];
    int          beats = 0;
    int          exp_pkt = 0;
    int          exp_err = 0;
    int          mon_pkt = 0;
    int          mon_err = 0;

    always #5 clk = ~clk;

    down_fifo_packet_reader dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .fifo_dat_i   (fifo_dat),
        .fifo_empty_i (fifo_empty),
        .fifo_valid_i (fifo_valid),
        .fifo_rd_en_o (fifo_rd_en),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_last_o   (out_last),
        .out_ready_i  (out_ready),
        .pkt_done_o   (pkt_done),
        .pkt_err_o    (pkt_err),
        .hdr_err_o    (hdr_err),
        .pkt_count_o  (pkt_count),
        .err_count_o  (err_count),
        .dbg_state_o  (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard (non-FWFT) FIFO: a pop requested in one cycle presents data the next.
    initial begin
        logic rd;
        fifo_valid = 1'b0;
        fifo_dat   = 32'd0;
        fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            rd = fifo_rd_en;
            @(posedge clk);
            #1;
            fifo_valid = 1'b0;
            fifo_dat   = 32'd0;
            if (rd && fifo_q.size() > 0) begin
                fifo_dat   = fifo_q.pop_front();
                fifo_valid = 1'b1;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Output beats, hold-under-stall, and done/header-error events with counters.
    initial begin
        logic        stall_prev;
        logic [32:0] word_prev;
        logic [1:0]  code;
        logic [1:0]  e;
        stall_prev = 1'b0;
        word_prev  = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (stall_prev) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_word", 64'({out_last, out_data}), 64'(word_prev));
                end
                if (out_valid && out_ready) begin
                    beats++;
                    if (exp_q.size() == 0) check("beat_extra", 64'({out_last, out_data}), 64'h1_0000_0000_0);
                    else check("beat", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
                end
                stall_prev = out_valid && !out_ready;
                word_prev  = {out_last, out_data};
                if (pkt_done || hdr_err) begin
                    code = hdr_err ? 2'd2 : (pkt_err ? 2'd1 : 2'd0);
                    if (ev_q.size() == 0) begin
                        check("event_extra", 64'({hdr_err, pkt_done}), 64'd0);
                    end else begin
                        e = ev_q.pop_front();
                        check("event", 64'(code), 64'(e));
                        if (e == 2'd0) mon_pkt++;
                        else mon_err++;
                        check("pkt_count_live", 64'(pkt_count), 64'(mon_pkt));
                        check("err_count_live", 64'(err_count), 64'(mon_err));
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_event(input logic [1:0] code);
        ev_q.push_back(code);
        if (code == 2'd0) exp_pkt++;
        else exp_err++;
    endtask

    task automatic push_packet(input int n, input bit bad);
        logic [31:0] w;
        logic [31:0] x;
        x = 32'd0;
        fifo_q.push_back({16'hA5A5, 16'(n)});
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            x = x ^ w;
            fifo_q.push_back(w);
            exp_q.push_back({(i == n - 1), w});
        end
        if (bad) x = x ^ (32'd1 << $urandom_range(31, 0));
        fifo_q.push_back(x);
        expect_event(bad ? 2'd1 : 2'd0);
    endtask

    task automatic push_junk();
        logic [31:0] w;
        w = $urandom;
        if (w[31:16] == 16'hA5A5) w[31:16] = 16'h5A5A;
        fifo_q.push_back(w);
        expect_event(2'd2);
    endtask

    task automatic drain(input bit rand_ready);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0 || fifo_q.size() != 0) && t < 3000) begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            t++;
        end
        out_ready = 1'b1;
        step(3);
        check("drain_left", 64'(exp_q.size() + ev_q.size() + fifo_q.size()), 64'd0);
        check("pkt_count", 64'(pkt_count), 64'(exp_pkt));
        check("err_count", 64'(err_count), 64'(exp_err));
    endtask

    task automatic wait_beats(input int target);
        int t;
        t = 0;
        while (beats < target && t < 300) begin
            step();
            t++;
        end
        check("wait_beats", 64'(beats >= target), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_word"}, 64'({out_last, out_data}), 64'd0);
        check({tag, "_pulses"}, 64'({pkt_done, pkt_err, hdr_err}), 64'd0);
        check({tag, "_counts"}, 64'({pkt_count, err_count}), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_HUNT));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        step(2);
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Directed good packet, XOR trailer 0x77.
        fifo_q.push_back(32'hA5A5_0003);
        fifo_q.push_back(32'h11);
        fifo_q.push_back(32'h22);
        fifo_q.push_back(32'h44);
        fifo_q.push_back(32'h77);
        exp_q.push_back({1'b0, 32'h11});
        exp_q.push_back({1'b0, 32'h22});
        exp_q.push_back({1'b1, 32'h44});
        expect_event(2'd0);
        drain(1'b0);

        // Same packet with a wrong trailer: payload still forwarded.
        fifo_q.push_back(32'hA5A5_0003);
        fifo_q.push_back(32'h11);
        fifo_q.push_back(32'h22);
        fifo_q.push_back(32'h44);
        fifo_q.push_back(32'h76);
        exp_q.push_back({1'b0, 32'h11});
        exp_q.push_back({1'b0, 32'h22});
        exp_q.push_back({1'b1, 32'h44});
        expect_event(2'd1);
        drain(1'b0);

        // Wrong magic, then a good packet.
        fifo_q.push_back(32'h1234_0002);
        expect_event(2'd2);
        push_packet(3, 1'b0);
        drain(1'b0);

        // Length limits: 0 and MAX_LEN+1 rejected, 1 and MAX_LEN accepted.
        fifo_q.push_back(32'hA5A5_0000);
        expect_event(2'd2);
        fifo_q.push_back(32'hA5A5_0401);
        expect_event(2'd2);
        drain(1'b0);
        check("len_state", 64'(dbg_state), 64'(ST_HUNT));
        push_packet(1, 1'b0);
        push_packet(1024, 1'b0);
        drain(1'b0);

        // Backpressure mid-payload for 10 cycles.
        out_ready = 1'b1;
        push_packet(8, 1'b0);
        wait_beats(beats + 2);
        out_ready = 1'b0;
        step(10);
        check("stall_rd_en", 64'(fifo_rd_en), 64'd0);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_state", 64'(dbg_state), 64'(ST_PAYLOAD));
        drain(1'b0);

        // Randomized stream of packets, junk words and corrupted trailers.
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 3) == 0) push_junk();
            push_packet($urandom_range(1, 12), ($urandom_range(0, 4) == 0));
        end
        drain(1'b1);

        // Reset in the middle of a 5-word payload.
        out_ready = 1'b1;
        push_packet(5, 1'b0);
        wait_beats(beats + 2);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        fifo_q.delete();
        @(posedge clk);
        #2;
        check_all_zero("midreset");
        exp_q.delete();
        ev_q.delete();
        exp_pkt = 0;
        exp_err = 0;
        mon_pkt = 0;
        mon_err = 0;
        reset_n = 1'b1;
        step(3);
        check("post_reset_valid", 64'(out_valid), 64'd0);
        check("post_reset_err", 64'(err_count), 64'd0);
        check("post_reset_state", 64'(dbg_state), 64'(ST_HUNT));
        push_packet(4, 1'b0);
        drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
